// File: rtl/mux_tree_take_blk_pipe_pkg.sv
// Shared types and constants for the pipelined sub-block select tree.
// The take-mode enum records whether a take fires outside or inside the range.
package mux_tree_take_blk_pipe_pkg;

    localparam int DEFAULT_NUM_IN = 16;
    localparam int DEFAULT_DATA_W = 32;

    typedef enum logic {
        TAKE_MODE_INSIDE  = 1'b0,
        TAKE_MODE_OUTSIDE = 1'b1
    } takeMode_t;

    // Ceiling log2. Used at elaboration time to size the select path.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/mux2_reg_en.sv
// Registered 2:1 mux with synchronous active-high reset and stall enable.
// s=0 forwards a, s=1 forwards b.
module mux2_reg_en
    import mux_tree_take_blk_pipe_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              s,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (en) begin
            q <= s ? b : a;
        end
    end

endmodule

// File: rtl/mux_tree_take_blk_pipe.sv
// Pipelined NUM_IN:1 select tree with aligned valid/take tags for the ping-pong merge.
// One 2:1 mux level per select bit, LSB first; latency equals SEL_W cycles.
module mux_tree_take_blk_pipe
    import mux_tree_take_blk_pipe_pkg::*;
#(
    parameter int NUM_IN       = DEFAULT_NUM_IN,
    parameter int DATA_W       = DEFAULT_DATA_W,
    parameter int SEL_W        = clog2(NUM_IN),
    parameter bit TAKE_OUTSIDE = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic                     flush,
    input  logic                     in_valid,
    input  logic [SEL_W-1:0]         sel,
    input  logic [NUM_IN*DATA_W-1:0] data_in,
    input  logic                     need_pang,
    input  logic                     my_turn,
    input  logic [SEL_W-1:0]         rng_start,
    input  logic [SEL_W-1:0]         rng_end,
    output logic [DATA_W-1:0]        data_out,
    output logic                     out_valid,
    output logic                     take_out
);

    localparam int        NODES     = 2 * NUM_IN - 1;
    localparam takeMode_t TAKE_MODE = TAKE_OUTSIDE ? TAKE_MODE_OUTSIDE : TAKE_MODE_INSIDE;

    // Heap-style node store: leaves first, then each level's outputs, root last.
    logic [DATA_W-1:0] node [NODES];

    // Bit k of sel, delayed k cycles so it meets its data at level k.
    logic [SEL_W-1:0] selAtLvl;

    logic inRange;
    logic hit;
    logic takeIn;

    logic [SEL_W-1:0] vldPipe;
    logic [SEL_W-1:0] takePipe;

    assign selAtLvl[0] = sel[0];

    for (genvar k = 1; k < SEL_W; k++) begin : gSelDly
        logic [k-1:0] dly;

        always_ff @(posedge clk) begin
            if (reset) begin
                dly <= '0;
            end else if (en) begin
                dly <= k'({dly, sel[k]});
            end
        end

        assign selAtLvl[k] = dly[k-1];
    end

    for (genvar i = 0; i < NUM_IN; i++) begin : gLeaf
        assign node[i] = data_in[i*DATA_W +: DATA_W];
    end

    for (genvar lvl = 0; lvl < SEL_W; lvl++) begin : gLevel
        localparam int IN_BASE  = 2 * NUM_IN - 2 * (NUM_IN >> lvl);
        localparam int OUT_BASE = 2 * NUM_IN - (NUM_IN >> lvl);

        for (genvar j = 0; j < (NUM_IN >> (lvl + 1)); j++) begin : gNode
            mux2_reg_en #(
                .DATA_W (DATA_W)
            ) uMux (
                .clk   (clk),
                .reset (reset),
                .en    (en),
                .s     (selAtLvl[lvl]),
                .a     (node[IN_BASE + 2*j]),
                .b     (node[IN_BASE + 2*j + 1]),
                .q     (node[OUT_BASE + j])
            );
        end
    end

    // An inverted range (start > end) never matches, so it reads as empty.
    always_comb begin
        inRange = (rng_start <= sel) && (sel <= rng_end);
        hit     = (TAKE_MODE == TAKE_MODE_OUTSIDE) ? !inRange : inRange;
        takeIn  = in_valid && my_turn && (hit || need_pang);
    end

    // Flush also clears the entry stage, so an item arriving with flush is dropped.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            vldPipe  <= '0;
            takePipe <= '0;
        end else if (en) begin
            vldPipe  <= SEL_W'({vldPipe, in_valid});
            takePipe <= SEL_W'({takePipe, takeIn});
        end
    end

    assign data_out  = node[NODES-1];
    assign out_valid = vldPipe[SEL_W-1];
    assign take_out  = takePipe[SEL_W-1];

endmodule

// File: tb/tb_mux_tree_take_blk_pipe.sv
// Bench for the pipelined select tree: scoreboard on the 16x8 outside-mode
// instance, plus direct checks on an inside-mode twin and a 4x16 instance.
module tb_mux_tree_take_blk_pipe;

    typedef struct {
        logic [7:0] data;
        logic       take;
        int         cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         en;
    logic         flush;
    logic         inValid;
    logic         needPang;
    logic         myTurn;
    logic [3:0]   sel;
    logic [3:0]   rngStart;
    logic [3:0]   rngEnd;
    logic [127:0] dataIn;

    logic [7:0]   dataOutA;
    logic         outValidA;
    logic         takeOutA;
    logic [7:0]   dataOutB;
    logic         outValidB;
    logic         takeOutB;

    logic         inValidC;
    logic [1:0]   selC;
    logic [1:0]   rngStartC;
    logic [1:0]   rngEndC;
    logic [63:0]  dataInC;
    logic [15:0]  dataOutC;
    logic         outValidC;
    logic         takeOutC;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t sb[$];
    exp_t head;
    bit   headSeen = 1'b0;

    mux_tree_take_blk_pipe #(.NUM_IN(16), .DATA_W(8), .TAKE_OUTSIDE(1'b1)) dutA (
        .clk(clk), .reset(reset), .en(en), .flush(flush), .in_valid(inValid),
        .sel(sel), .data_in(dataIn), .need_pang(needPang), .my_turn(myTurn),
        .rng_start(rngStart), .rng_end(rngEnd),
        .data_out(dataOutA), .out_valid(outValidA), .take_out(takeOutA)
    );

    mux_tree_take_blk_pipe #(.NUM_IN(16), .DATA_W(8), .TAKE_OUTSIDE(1'b0)) dutB (
        .clk(clk), .reset(reset), .en(en), .flush(flush), .in_valid(inValid),
        .sel(sel), .data_in(dataIn), .need_pang(needPang), .my_turn(myTurn),
        .rng_start(rngStart), .rng_end(rngEnd),
        .data_out(dataOutB), .out_valid(outValidB), .take_out(takeOutB)
    );

    mux_tree_take_blk_pipe #(.NUM_IN(4), .DATA_W(16), .TAKE_OUTSIDE(1'b1)) dutC (
        .clk(clk), .reset(reset), .en(en), .flush(flush), .in_valid(inValidC),
        .sel(selC), .data_in(dataInC), .need_pang(needPang), .my_turn(myTurn),
        .rng_start(rngStartC), .rng_end(rngEndC),
        .data_out(dataOutC), .out_valid(outValidC), .take_out(takeOutC)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    // Output monitor for dutA: an item is consumed on a cycle where en=1.
    always @(negedge clk) begin
        if (!reset) begin
            if (outValidA) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_valid cyc=%0d data=%h take=%b", cyc, dataOutA, takeOutA);
                end else begin
                    head = sb[0];
                    if (dataOutA !== head.data || takeOutA !== head.take || (!headSeen && cyc != head.cyc)) begin
                        errors++;
                        $display("FAIL scoreboard cyc=%0d got data=%h take=%b, want data=%h take=%b cyc=%0d",
                                 cyc, dataOutA, takeOutA, head.data, head.take, head.cyc);
                    end
                    if (en) begin
                        void'(sb.pop_front());
                        headSeen = 1'b0;
                    end else begin
                        headSeen = 1'b1;
                    end
                end
            end else if (takeOutA !== 1'b0) begin
                checks++;
                errors++;
                $display("FAIL take_without_valid cyc=%0d take=%b want 0", cyc, takeOutA);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    // Drives one dutA input for a cycle and records its expected result.
    task automatic put(input logic [3:0] s, input int extra);
        exp_t e;
        logic inR;
        sel     = s;
        inValid = 1'b1;
        inR     = (rngStart <= s) && (s <= rngEnd);
        e.data  = 8'h10 + {4'h0, s};
        e.take  = myTurn && (!inR || needPang);
        e.cyc   = cyc + 4 + extra;
        if (en && !flush) sb.push_back(e);
        step();
        inValid = 1'b0;
    endtask

    task automatic test_reset();
        idle(2);
        checks++;
        if (dataOutA !== 8'h00 || outValidA !== 1'b0 || takeOutA !== 1'b0) begin
            errors++;
            $display("FAIL reset_A data=%h valid=%b take=%b want 00 0 0", dataOutA, outValidA, takeOutA);
        end
        checks++;
        if (dataOutC !== 16'h0000 || outValidC !== 1'b0 || takeOutC !== 1'b0) begin
            errors++;
            $display("FAIL reset_C data=%h valid=%b take=%b want 0000 0 0", dataOutC, outValidC, takeOutC);
        end
        reset = 1'b0;
        idle(2);
    endtask

    task automatic test_basic();
        put(3, 0);
        idle(4);
        put(5, 0);
        idle(4);
    endtask

    task automatic test_range_edges();
        put(4, 0);
        put(9, 0);
        put(10, 0);
        rngStart = 9;
        rngEnd   = 4;
        put(6, 0);
        rngStart = 4;
        rngEnd   = 9;
        idle(5);
    endtask

    task automatic test_inside();
        put(4, 0);
        idle(3);
        checks++;
        if (outValidB !== 1'b1 || dataOutB !== 8'h14 || takeOutB !== 1'b1) begin
            errors++;
            $display("FAIL inside_sel4 valid=%b data=%h take=%b want 1 14 1", outValidB, dataOutB, takeOutB);
        end
        put(10, 0);
        idle(3);
        checks++;
        if (outValidB !== 1'b1 || dataOutB !== 8'h1a || takeOutB !== 1'b0) begin
            errors++;
            $display("FAIL inside_sel10 valid=%b data=%h take=%b want 1 1a 0", outValidB, dataOutB, takeOutB);
        end
        idle(2);
    endtask

    task automatic test_qualifiers();
        needPang = 1'b1;
        put(6, 0);
        needPang = 1'b0;
        myTurn   = 1'b0;
        put(0, 0);
        myTurn   = 1'b1;
        idle(5);
    endtask

    task automatic test_back_to_back();
        for (int s = 0; s < 16; s++) put(4'(s), 0);
        idle(6);
    endtask

    task automatic test_stall();
        logic [7:0] dHold;
        logic       vHold;
        put(2, 3);
        put(7, 3);
        dHold   = dataOutA;
        vHold   = outValidA;
        en      = 1'b0;
        sel     = 9;
        inValid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (dataOutA !== dHold || outValidA !== vHold) begin
                errors++;
                $display("FAIL stall_hold data=%h valid=%b want %h %b", dataOutA, outValidA, dHold, vHold);
            end
        end
        inValid = 1'b0;
        en      = 1'b1;
        idle(8);
        put(12, 0);
        idle(3);
        en = 1'b0;
        idle(2);
        en = 1'b1;
        idle(3);
    endtask

    task automatic test_flush();
        sel     = 5;
        inValid = 1'b1;
        step();
        inValid = 1'b0;
        step();
        flush   = 1'b1;
        sel     = 6;
        inValid = 1'b1;
        step();
        flush   = 1'b0;
        inValid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if (outValidA !== 1'b0) begin
                errors++;
                $display("FAIL flush_valid cyc=%0d valid=%b want 0", cyc, outValidA);
            end
        end
    endtask

    task automatic test_reset_mid();
        put(1, 0);
        put(8, 0);
        put(13, 0);
        reset = 1'b1;
        sb.delete();
        headSeen = 1'b0;
        step();
        checks++;
        if (dataOutA !== 8'h00 || outValidA !== 1'b0 || takeOutA !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid data=%h valid=%b take=%b want 00 0 0", dataOutA, outValidA, takeOutA);
        end
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if (outValidA !== 1'b0) begin
                errors++;
                $display("FAIL stale_valid cyc=%0d valid=%b want 0", cyc, outValidA);
            end
        end
        put(11, 0);
        idle(5);
    endtask

    task automatic test_small();
        selC     = 3;
        inValidC = 1'b1;
        step();
        inValidC = 1'b0;
        checks++;
        if (outValidC !== 1'b0) begin
            errors++;
            $display("FAIL small_early valid=%b want 0", outValidC);
        end
        step();
        checks++;
        if (outValidC !== 1'b1 || dataOutC !== 16'ha003 || takeOutC !== 1'b1) begin
            errors++;
            $display("FAIL small_lat2 valid=%b data=%h take=%b want 1 a003 1", outValidC, dataOutC, takeOutC);
        end
        selC     = 1;
        inValidC = 1'b1;
        step();
        selC     = 2;
        step();
        inValidC = 1'b0;
        reset    = 1'b1;
        sb.delete();
        headSeen = 1'b0;
        step();
        checks++;
        if (dataOutC !== 16'h0000 || outValidC !== 1'b0 || takeOutC !== 1'b0) begin
            errors++;
            $display("FAIL small_reset data=%h valid=%b take=%b want 0000 0 0", dataOutC, outValidC, takeOutC);
        end
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (outValidC !== 1'b0) begin
                errors++;
                $display("FAIL small_stale valid=%b want 0", outValidC);
            end
        end
        selC     = 0;
        inValidC = 1'b1;
        step();
        inValidC = 1'b0;
        step();
        checks++;
        if (outValidC !== 1'b1 || dataOutC !== 16'ha000 || takeOutC !== 1'b1) begin
            errors++;
            $display("FAIL small_post_reset valid=%b data=%h take=%b want 1 a000 1", outValidC, dataOutC, takeOutC);
        end
        idle(3);
    endtask

    initial begin
        reset     = 1'b1;
        en        = 1'b1;
        flush     = 1'b0;
        inValid   = 1'b0;
        sel       = 4'd0;
        needPang  = 1'b0;
        myTurn    = 1'b1;
        rngStart  = 4'd4;
        rngEnd    = 4'd9;
        inValidC  = 1'b0;
        selC      = 2'd0;
        rngStartC = 2'd1;
        rngEndC   = 2'd2;
        for (int i = 0; i < 16; i++) dataIn[i*8 +: 8] = 8'h10 + 8'(i);
        for (int i = 0; i < 4; i++) dataInC[i*16 +: 16] = 16'ha000 + 16'(i);

        test_reset();
        test_basic();
        test_range_edges();
        test_inside();
        test_qualifiers();
        test_back_to_back();
        test_stall();
        test_flush();
        test_reset_mid();
        test_small();

        for (int i = 0; i < 50 && sb.size() != 0; i++) step();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout pending=%0d want 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
